riscv_fetch_queue: RTL
======================

// Module: riscv_fetch_queue
// PURPOSE
// - Parametrised instruction-fetch front end: owns the fetch PC, issues reads to the sync instruction memory,
//   buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, hands them to decode via valid/ready.
// - Replaces the single-PC fetch register; adds prefetch, decoupled decode backpressure and redirect flush.
// PARAMETERS
// - PC_WIDTH    14    fetch PC bits; PC wraps mod 2**PC_WIDTH
// - RESET_PC    0     PC loaded on reset (word aligned)
// - DEPTH       4     queue entries; power of 2, >=2
// - INST_WIDTH  32    instruction word width
// PORTS
// - clk             in   1           clock, all state on posedge
// - rst             in   1           synchronous reset, ACTIVE-LOW (rst==0 resets)
// - stall           in   1           memory-system stall; freezes all state
// - redirect        in   1           branch/jump taken in execute; flush and refetch
// - redirect_pc     in   PC_WIDTH    target PC; bits [1:0] ignored (forced 0)
// - icache_addr     out  32          read address, zero-extended fetch PC
// - icache_re       out  1           read enable; data returns on instruction next cycle
// - instruction     in   INST_WIDTH  imem read data, valid 1 cycle after icache_re
// - deq_valid       out  1           queue head valid
// - deq_ready       in   1           decode accepts head this cycle
// - deq_inst        out  INST_WIDTH  head instruction (NOP 32'h13 when !deq_valid)
// - deq_pc          out  PC_WIDTH    head PC
// - deq_pc_plus4    out  PC_WIDTH    head PC+4 (wrapped), for JAL/JALR link
// - occupancy       out  $clog2(DEPTH)+1  valid entries in queue
// BEHAVIOUR
// - Reset (rst==0): fetch_pc=RESET_PC, queue empty, in-flight cleared; icache_re=0, icache_addr=RESET_PC,
//   deq_valid=0, deq_inst=NOP, occupancy=0. First read issued in first cycle with rst==1.
// - Issue: icache_re=1 iff rst && !stall && !redirect && (occupancy + inflight - deq_fire) < DEPTH;
//   on issue fetch_pc<=fetch_pc+4, inflight<=1, tag_pc<=fetch_pc.
// - Return: cycle after an issue (with !stall), {instruction, tag_pc} written to tail unless squashed.
//   Issue-to-deq_valid latency = 2 cycles; no bypass around the queue.
// - Dequeue: deq_fire = deq_valid && deq_ready && !stall; deq_valid = !empty && !redirect.
//   Enqueue and dequeue in the same cycle allowed at any occupancy incl. full; occupancy unchanged.
// - Full: no issue; in-flight read always has a reserved slot (credit counted at issue), never dropped.
// - Empty: deq_valid=0, deq_inst=NOP, deq_pc holds last value.
// - Redirect (with !stall): queue flushed, in-flight response squashed (not enqueued), no deq_fire,
//   fetch_pc<=redirect_pc&~3; first read of target issued next cycle; target deq_valid 3 cycles after redirect.
// - Stall: stall has priority over everything; all registers hold, icache_re=0, redirect ignored
//   (execute holds redirect until stall drops); in-flight data captured in the first !stall cycle
//   (memory holds its output during stall).
// - Redirect + deq_ready same cycle: redirect wins. Redirect + reset: reset wins.
// - Wrap: fetch_pc and pc_plus4 wrap mod 2**PC_WIDTH; head/tail pointers wrap mod DEPTH.
// - Reset mid-operation: all queue contents and in-flight read discarded; data on instruction next cycle ignored.
// STRUCTURE
// - Package riscv_fetch_pkg: NOP_INST=32'h13, default PC_WIDTH/DEPTH, fetch_entry_t {inst, pc}.
// - Sub-module sync_fifo (DEPTH x fetch_entry_t, push/pop/flush, count); top holds PC, credit, squash logic.
// - All outputs combinational from registers only (no path from instruction to deq_*).
// TESTING
// - Reset release, deq_ready=1: icache_addr 0,4,8,...; deq_pc 0 at cycle 2, then +4 each cycle, deq_pc_plus4=deq_pc+4.
// - deq_ready=0 for 10 cycles, DEPTH=4: occupancy saturates at 4, icache_re low, no entry lost;
//   release -> deq_pc 0,4,8,12,16 consecutive.
// - redirect to 0x104 while 3 entries queued + 1 in flight: occupancy 0 next cycle, icache_addr 0x104,
//   deq_valid 3 cycles after redirect with deq_pc=0x104; no stale PC ever dequeued.
// - stall=1 for 5 cycles mid-stream with redirect asserted: state frozen, icache_re=0; on release redirect taken.
// - PC_WIDTH=14, redirect_pc=0x3FFC: deq_pc 0x3FFC then 0x0000, deq_pc_plus4 of 0x3FFC is 0x0000.
// - rst=0 mid-stream for 1 cycle: occupancy 0, deq_valid 0, fetch restarts at RESET_PC, old in-flight data dropped.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and the default queue entry type for the instruction-fetch front end.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam int          PC_WIDTH_DEF   = 14;
    localparam int          DEPTH_DEF      = 4;
    localparam int          INST_WIDTH_DEF = 32;

    typedef struct packed {
        logic [INST_WIDTH_DEF-1:0] inst;
        logic [PC_WIDTH_DEF-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Fetch front-end bus: control from execute, icache read port and decode handshake.
interface riscv_fetch_queue_if
    import riscv_fetch_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  stall;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [31:0]           icache_addr;
    logic                  icache_re;
    logic [INST_WIDTH-1:0] instruction;
    logic                  deq_valid;
    logic                  deq_ready;
    logic [INST_WIDTH-1:0] deq_inst;
    logic [PC_WIDTH-1:0]   deq_pc;
    logic [PC_WIDTH-1:0]   deq_pc_plus4;
    logic [CW-1:0]         occupancy;

    modport master (
        input  stall, redirect, redirect_pc, instruction, deq_ready,
        output icache_addr, icache_re, deq_valid, deq_inst, deq_pc, deq_pc_plus4, occupancy
    );

    modport slave (
        output stall, redirect, redirect_pc, instruction, deq_ready,
        input  icache_addr, icache_re, deq_valid, deq_inst, deq_pc, deq_pc_plus4, occupancy
    );

endinterface

// File: rtl/riscv_fetch_queue_sync_fifo.sv
// Synchronous circular FIFO with flush; simultaneous push and pop allowed at any fill level.
module sync_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     count_q;

    // Pointer and count update; flush discards everything.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (rst && !flush_i && push_i) mem_q[wr_q] <= wdata_i;
    end

    // Head view and status.
    always_comb begin
        rdata_o = mem_q[rd_q];
        count_o = count_q;
        empty_o = (count_q == '0);
    end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues icache reads with slot credits,
// buffers returned words with their PCs and presents them to decode.
module riscv_fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int                   PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int                   DEPTH      = DEPTH_DEF,
    parameter int                   INST_WIDTH = INST_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    riscv_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] tag_pc_q, tag_pc_d;
    logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                inflight_q, inflight_d;

    logic                deq_valid_s;
    logic                deq_fire_s;
    logic                issue_s;
    logic                push_s;
    logic                flush_s;
    logic [OW-1:0]       credit_s;
    logic [PC_WIDTH-1:0] deq_pc_s;
    entry_t              wdata_s;
    entry_t              head_s;
    logic [CW-1:0]       count_s;
    logic                empty_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (deq_fire_s),
        .flush_i (flush_s),
        .wdata_i (wdata_s),
        .rdata_o (head_s),
        .count_o (count_s),
        .empty_o (empty_s)
    );

    // Handshake, credit and queue-control decisions for this cycle.
    always_comb begin
        deq_valid_s = rst && !empty_s && !bus.redirect;
        deq_fire_s  = deq_valid_s && bus.deq_ready && !bus.stall;
        // An outstanding read already owns a slot, so it is counted before issuing again.
        credit_s    = OW'(count_s) + OW'(inflight_q) - OW'(deq_fire_s);
        issue_s     = rst && !bus.stall && !bus.redirect && (credit_s < OW'(DEPTH));
        flush_s     = rst && !bus.stall && bus.redirect;
        push_s      = rst && !bus.stall && !bus.redirect && inflight_q;
        wdata_s     = '{inst: bus.instruction, pc: tag_pc_q};
    end

    // Next-state for PC, in-flight tag and last dequeued PC; stall freezes everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        last_pc_d  = last_pc_q;
        inflight_d = inflight_q;
        if (bus.stall) begin
            inflight_d = inflight_q;
        end else if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue_s;
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
                tag_pc_d   = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (deq_fire_s) begin
                last_pc_d = head_s.pc;
            end else begin
                last_pc_d = last_pc_q;
            end
        end
    end

    // Fetch state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Output drive; deq_* depend only on registered state and control inputs.
    always_comb begin
        deq_pc_s         = (rst && !empty_s) ? head_s.pc : last_pc_q;
        bus.icache_re    = issue_s;
        bus.icache_addr  = rst ? 32'(fetch_pc_q) : 32'(RESET_PC);
        bus.deq_valid    = deq_valid_s;
        bus.deq_inst     = deq_valid_s ? head_s.inst : INST_WIDTH'(NOP_INST);
        bus.deq_pc       = deq_pc_s;
        bus.deq_pc_plus4 = deq_pc_s + PC_WIDTH'(4);
        bus.occupancy    = rst ? count_s : CW'(0);
    end

endmodule
